// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter for a single shared resource.
// A grant is registered (one-hot plus encoded index) and kept until the owner
// reports done, drops its request, or runs into the MAX_HOLD limit. Every
// ownership is followed by one idle cycle in which the next winner is chosen.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // A MAX_HOLD of zero turns the hold limit off entirely.
    localparam bit                LIMIT_EN  = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LIMIT_EN ? MAX_HOLD - 1 : 0);

    state_t            state_q;
    logic [3:0]        gnt_q;
    logic [1:0]        gntIdx_q;
    logic [1:0]        last_q;
    logic              timeout_q;
    logic [HOLD_W-1:0] hold_q;

    logic [1:0]        winnerIdx;
    logic              winnerValid;
    logic [1:0]        candIdx;

    // Rotating priority search: last+1 is checked first and the previous
    // owner last. The loop runs from lowest to highest priority so the final
    // match standing is the winner.
    always_comb begin
        winnerValid = 1'b0;
        winnerIdx   = last_q;
        candIdx     = last_q;
        for (int k = 4; k >= 1; k--) begin
            candIdx = last_q + 2'(k);
            if (req[candIdx]) begin
                winnerValid = 1'b1;
                winnerIdx   = candIdx;
            end
        end
    end

    // Arbitration FSM. Every output comes straight from a register, so req
    // never reaches gnt combinationally. done has priority over the hold
    // limit, so a simultaneous done suppresses the timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            gntIdx_q  <= 2'd0;
            last_q    <= 2'd3;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (winnerValid) begin
                        gnt_q    <= 4'b0001 << winnerIdx;
                        gntIdx_q <= winnerIdx;
                        hold_q   <= '0;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    if (done || !req[gntIdx_q]) begin
                        gnt_q   <= 4'b0000;
                        last_q  <= gntIdx_q;
                        state_q <= IDLE;
                    end else if (LIMIT_EN && (hold_q == HOLD_LAST)) begin
                        gnt_q     <= 4'b0000;
                        last_q    <= gntIdx_q;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (LIMIT_EN) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    gnt_q   <= 4'b0000;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gntIdx_q;
    assign busy    = |gnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed bench for the four-way round-robin arbiter.
// Each scenario holds a table of per-cycle inputs and the hand-derived output
// word {gnt, gnt_idx, busy, timeout} expected after the clock edge on which
// those inputs are sampled.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int testsRun;
    int failures;

    rr_arbiter4 #(
        .MAX_HOLD(8),
        .HOLD_W  (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .busy   (busy),
        .timeout(timeout)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous reset with all requests idle, leaving rst low afterwards.
    task automatic doReset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset must hold every output low even with requests and done pending.
    task automatic test_reset();
        logic [7:0] obs;
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {gnt, gnt_idx, busy, timeout};
            testsRun++;
            if (obs !== 8'b0000_00_0_0) begin
                failures++;
                $display("[TB] FAIL reset cycle %0d: got %b, expected %b", i, obs, 8'b0000_00_0_0);
            end
        end
        rst  = 1'b0;
        req  = 4'b0000;
        done = 1'b0;
    endtask

    // One requester: three grant cycles ended by done, one idle cycle, regrant.
    task automatic test_single();
        logic [3:0] reqV [5];
        logic       doneV[5];
        logic [7:0] expV [5];
        logic [7:0] obs;
        reqV  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        doneV = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        expV  = '{8'b0010_01_1_0, 8'b0010_01_1_0, 8'b0010_01_1_0,
                  8'b0000_01_0_0, 8'b0010_01_1_0};
        doReset();
        for (int i = 0; i < 5; i++) begin
            req  = reqV[i];
            done = doneV[i];
            tick();
            obs = {gnt, gnt_idx, busy, timeout};
            testsRun++;
            if (obs !== expV[i]) begin
                failures++;
                $display("[TB] FAIL single cycle %0d: got %b, expected %b", i, obs, expV[i]);
            end
        end
    endtask

    // All four requesting: ownership rotates 0,1,2,3,0 with an idle gap each.
    task automatic test_round_robin();
        logic [7:0] expV[13];
        logic [7:0] obs;
        expV = '{8'b0001_00_1_0, 8'b0001_00_1_0, 8'b0000_00_0_0,
                 8'b0010_01_1_0, 8'b0010_01_1_0, 8'b0000_01_0_0,
                 8'b0100_10_1_0, 8'b0100_10_1_0, 8'b0000_10_0_0,
                 8'b1000_11_1_0, 8'b1000_11_1_0, 8'b0000_11_0_0,
                 8'b0001_00_1_0};
        doReset();
        for (int i = 0; i < 13; i++) begin
            req  = 4'b1111;
            done = ((i % 3) == 2);
            tick();
            obs = {gnt, gnt_idx, busy, timeout};
            testsRun++;
            if (obs !== expV[i]) begin
                failures++;
                $display("[TB] FAIL round_robin cycle %0d: got %b, expected %b", i, obs, expV[i]);
            end
        end
    endtask

    // Hold limit: eight grant cycles, one timeout pulse, then a fresh grant.
    task automatic test_hold_limit();
        logic [7:0] expV[11];
        logic [7:0] obs;
        for (int i = 0; i < 8; i++) expV[i] = 8'b0100_10_1_0;
        expV[8]  = 8'b0000_10_0_1;
        expV[9]  = 8'b0100_10_1_0;
        expV[10] = 8'b0100_10_1_0;
        doReset();
        for (int i = 0; i < 11; i++) begin
            req  = 4'b0100;
            done = 1'b0;
            tick();
            obs = {gnt, gnt_idx, busy, timeout};
            testsRun++;
            if (obs !== expV[i]) begin
                failures++;
                $display("[TB] FAIL hold_limit cycle %0d: got %b, expected %b", i, obs, expV[i]);
            end
        end
    endtask

    // Owner drops its request: release, idle cycle, then requester 3 wins.
    task automatic test_owner_drop();
        logic [3:0] reqV[4];
        logic [7:0] expV[4];
        logic [7:0] obs;
        reqV = '{4'b1001, 4'b1000, 4'b1000, 4'b1000};
        expV = '{8'b0001_00_1_0, 8'b0000_00_0_0, 8'b1000_11_1_0, 8'b1000_11_1_0};
        doReset();
        for (int i = 0; i < 4; i++) begin
            req  = reqV[i];
            done = 1'b0;
            tick();
            obs = {gnt, gnt_idx, busy, timeout};
            testsRun++;
            if (obs !== expV[i]) begin
                failures++;
                $display("[TB] FAIL owner_drop cycle %0d: got %b, expected %b", i, obs, expV[i]);
            end
        end
    endtask

    // done on the final allowed grant cycle wins over the limit: no timeout.
    task automatic test_done_vs_limit();
        logic [7:0] expV[10];
        logic [7:0] obs;
        for (int i = 0; i < 8; i++) expV[i] = 8'b0100_10_1_0;
        expV[8] = 8'b0000_10_0_0;
        expV[9] = 8'b0100_10_1_0;
        doReset();
        for (int i = 0; i < 10; i++) begin
            req  = 4'b0100;
            done = (i == 8);
            tick();
            obs = {gnt, gnt_idx, busy, timeout};
            testsRun++;
            if (obs !== expV[i]) begin
                failures++;
                $display("[TB] FAIL done_vs_limit cycle %0d: got %b, expected %b", i, obs, expV[i]);
            end
        end
    endtask

    // done is ignored while idle but releases the grant once busy.
    task automatic test_idle_done();
        logic [3:0] reqV[3];
        logic [7:0] expV[3];
        logic [7:0] obs;
        reqV = '{4'b0000, 4'b0010, 4'b0010};
        expV = '{8'b0000_00_0_0, 8'b0010_01_1_0, 8'b0000_01_0_0};
        doReset();
        for (int i = 0; i < 3; i++) begin
            req  = reqV[i];
            done = 1'b1;
            tick();
            obs = {gnt, gnt_idx, busy, timeout};
            testsRun++;
            if (obs !== expV[i]) begin
                failures++;
                $display("[TB] FAIL idle_done cycle %0d: got %b, expected %b", i, obs, expV[i]);
            end
        end
    endtask

    // Reset while requester 2 owns: outputs clear and requester 0 wins next.
    task automatic test_reset_mid_grant();
        logic       rstV [8];
        logic       doneV[8];
        logic [7:0] expV [8];
        logic [7:0] obs;
        rstV  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        doneV = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        expV  = '{8'b0001_00_1_0, 8'b0000_00_0_0, 8'b0010_01_1_0, 8'b0000_01_0_0,
                  8'b0100_10_1_0, 8'b0000_00_0_0, 8'b0001_00_1_0, 8'b0001_00_1_0};
        doReset();
        for (int i = 0; i < 8; i++) begin
            rst  = rstV[i];
            req  = 4'b1111;
            done = doneV[i];
            tick();
            obs = {gnt, gnt_idx, busy, timeout};
            testsRun++;
            if (obs !== expV[i]) begin
                failures++;
                $display("[TB] FAIL reset_mid_grant cycle %0d: got %b, expected %b", i, obs, expV[i]);
            end
        end
        rst = 1'b0;
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        testsRun = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        done     = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_limit();
        test_owner_drop();
        test_done_vs_limit();
        test_idle_done();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter that shares one resource, such as a downstream encoder or datapath, among 4 requesters.
- Registers a one-hot grant and its 2-bit encoded index.
- Holds the grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits between the requesting blocks and the shared combinational unit and drives its select/enable.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 disables the limit.
- HOLD_W, 4, hold counter width; must satisfy 2^HOLD_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i.
- done  input  1  current owner finished; sampled only while busy.
- gnt  output  4  registered one-hot grant; all zero when idle.
- gnt_idx  output  2  binary index of the owner; holds the last owner when idle.
- busy  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst=1 at clk edge):
  - Outputs: gnt=0000, gnt_idx=00, busy=0, timeout=0.
  - Internal state: state=IDLE, hold counter=0, last-owner pointer=3, so requester 0 has top priority first.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req!=0, pick the first set bit searching last+1, last+2, last+3, last (mod 4).
  - Next cycle: gnt=onehot(winner), gnt_idx=winner, busy=1, counter=0, state=GRANT.
  - Latency from req asserted to gnt is 1 clock.
  - done is ignored in IDLE.
- GRANT release conditions, evaluated each cycle in this priority order:
  - (a) done=1 → release, timeout=0.
  - (b) req[owner]=0 → release, timeout=0.
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD-1 → release; next cycle timeout=1.
  - Otherwise counter+1 and the grant is held.
- Release:
  - Next cycle: gnt=0000, busy=0, last=owner, state=IDLE.
  - gnt_idx keeps the owner value.
  - timeout is high only in that cycle, and only for cause (c).
- Consequences of the FSM:
  - There is always exactly one idle cycle between consecutive grants, even with pending requests. Back-to-back grants to the same requester are allowed only if no other requester is pending.
  - Fairness: a continuously requesting requester waits at most 3 ownerships.
  - An owner holds gnt for at most MAX_HOLD cycles.
- Request changes: requests from non-owners during GRANT have no effect until the next IDLE arbitration. A req bit dropping while its requester waits removes it from arbitration with no memory.
- Simultaneous done and limit: done wins and timeout stays 0.
- Reset mid-grant: gnt clears on the next edge and the pointer returns to 3.
- gnt is always one-hot or zero; no combinational path from req to gnt.
- Counter never wraps: it saturates at MAX_HOLD-1 and is cleared on every new grant. With MAX_HOLD=0 the counter is unused.

Test Plan:
1. Single request, rst released, req=0010 held, done pulsed on the 3rd grant cycle → gnt=0010, gnt_idx=01 from cycle 1 for 3 cycles; then gnt=0000, busy=0, timeout=0; then re-grant to 0010 after 1 idle cycle.
2. Round robin, req=1111 constant, done pulsed after 2 grant cycles each → grant order gnt_idx 0,1,2,3,0 with one idle cycle between each; no timeout.
3. Hold limit, MAX_HOLD=8, req=0100 constant, done=0 → gnt=0100 for exactly 8 cycles; next cycle gnt=0000 and timeout=1 for one cycle; then gnt=0100 again.
4. Owner drops request, req=1001 → grant 0001; req becomes 1000 → next cycle gnt=0000; the cycle after, gnt=1000, gnt_idx=11.
5. Simultaneous done and limit: done=1 on the 8th grant cycle with MAX_HOLD=8 → release with timeout=0.
6. Reset mid-grant: req=1111, owner 2 granted; rst=1 for 1 cycle → gnt=0000, gnt_idx=00; after rst=0 the next grant goes to requester 0 (pointer reset to 3).
